// File: rtl/neuron_pkg.sv
// Shared definitions for the sequential binary-weight neuron: FSM state
// encoding, beat-count helper and saturation bounds for a given ACC_W.
package neuron_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACC,
    S_DONE
  } state_t;

  // Number of LANES-wide beats needed to cover n pixels.
  function automatic int unsigned beats(input int unsigned n, input int unsigned lanes);
    return (n + lanes - 1) / lanes;
  endfunction

  // Largest value representable in a w-bit two's-complement accumulator.
  function automatic longint sat_hi(input int unsigned w);
    return (longint'(1) <<< (w - 1)) - 1;
  endfunction

  // Smallest value representable in a w-bit two's-complement accumulator.
  function automatic longint sat_lo(input int unsigned w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage

// File: rtl/neuron_lane_sum.sv
// Combinational signed adder tree for one input beat. Each enabled lane
// contributes +pixel (weight 1) or -pixel (weight 0), pixels zero-extended.
// Lane k's weight lives at weight[LANES-1-k]; disabled lanes contribute 0.
module neuron_lane_sum #(
  parameter int unsigned SIZE_WORD = 8,
  parameter int unsigned LANES     = 8,
  parameter int unsigned SUM_W     = 20
) (
  input  logic [SIZE_WORD*LANES-1:0] image,
  input  logic [LANES-1:0]           weight,
  input  logic [LANES-1:0]           en,
  output logic signed [SUM_W-1:0]    sum
);

  // Accumulate the signed per-lane terms of the current beat.
  always_comb begin
    logic signed [SUM_W-1:0] term;
    sum  = '0;
    term = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      term = SUM_W'(image[SIZE_WORD*k +: SIZE_WORD]);
      if (en[k]) begin
        if (weight[LANES-1-k]) sum = sum + term;
        else                   sum = sum - term;
      end
    end
  end

endmodule

// File: rtl/neuron_seq_acc.sv
// Sequential binary-weight neuron: streams NUMBER_IMAGE pixels in LANES-wide
// beats, accumulates +/- pixel on top of a bias, and emits one signed result
// per image over a valid/ready port.
// Optional: define NEURON_SAT_EN to clamp the accumulator after every beat;
// otherwise it wraps modulo 2^ACC_W.
module neuron_seq_acc
  import neuron_pkg::*;
#(
  parameter int unsigned SIZE_WORD    = 8,
  parameter int unsigned NUMBER_IMAGE = 121,
  parameter int unsigned LANES        = 8,
  parameter int unsigned ACC_W        = 2 * SIZE_WORD
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clear,
  input  logic signed [ACC_W-1:0]     bias,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [SIZE_WORD*LANES-1:0]  in_image,
  input  logic [LANES-1:0]            in_weight,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [ACC_W-1:0]     out
);

  localparam int unsigned BEATS      = beats(NUMBER_IMAGE, LANES);
  localparam int unsigned CNT_W      = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned SUM_W      = ACC_W + $clog2(LANES) + 1;
  localparam int unsigned EXT_W      = SUM_W + 1;
  localparam int unsigned LAST_LANES = NUMBER_IMAGE - (BEATS - 1) * LANES;

`ifdef NEURON_SAT_EN
  localparam logic signed [EXT_W-1:0] ACC_HI = EXT_W'(sat_hi(ACC_W));
  localparam logic signed [EXT_W-1:0] ACC_LO = EXT_W'(sat_lo(ACC_W));
`endif

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [ACC_W-1:0]  acc_nxt;
  logic signed [ACC_W-1:0]  base;
  logic signed [EXT_W-1:0]  sum_ext;
  logic signed [SUM_W-1:0]  beat_sum;
  logic [LANES-1:0]         lane_en;
  logic                     accept;
  logic                     is_last;

  assign in_ready = (state_q != S_DONE);
  assign accept   = in_valid && in_ready;
  // In S_IDLE the counter is 0, so a single-beat image is "last" immediately.
  assign is_last  = (cnt_q == CNT_W'(BEATS - 1));

  // Mask off lanes past NUMBER_IMAGE on the (possibly partial) final beat.
  always_comb begin
    lane_en = '1;
    if (is_last) begin
      for (int unsigned k = 0; k < LANES; k++) lane_en[k] = (k < LAST_LANES);
    end
  end

  neuron_lane_sum #(
    .SIZE_WORD (SIZE_WORD),
    .LANES     (LANES),
    .SUM_W     (SUM_W)
  ) u_lane_sum (
    .image  (in_image),
    .weight (in_weight),
    .en     (lane_en),
    .sum    (beat_sum)
  );

  // Next accumulator value: bias starts a new image, otherwise add to acc.
  always_comb begin
    base    = (state_q == S_IDLE) ? bias : acc_q;
    sum_ext = {{(EXT_W-ACC_W){base[ACC_W-1]}}, base}
            + {{(EXT_W-SUM_W){beat_sum[SUM_W-1]}}, beat_sum};
`ifdef NEURON_SAT_EN
    if (sum_ext > ACC_HI)      acc_nxt = ACC_W'(ACC_HI);
    else if (sum_ext < ACC_LO) acc_nxt = ACC_W'(ACC_LO);
    else                       acc_nxt = ACC_W'(sum_ext);
`else
    acc_nxt = ACC_W'(sum_ext);
`endif
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; clear overrides beats and output handshakes.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_ACC: if (accept) state_d = is_last ? S_DONE : S_ACC;
        S_DONE:        if (out_ready) state_d = S_IDLE;
        default:       state_d = S_IDLE;
      endcase
    end
  end

  // Beat counter, accumulator and held output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      acc_q     <= '0;
      out       <= '0;
      out_valid <= 1'b0;
    end else if (clear) begin
      cnt_q     <= '0;
      out_valid <= 1'b0;
    end else if (accept) begin
      acc_q <= acc_nxt;
      if (is_last) begin
        cnt_q     <= '0;
        out       <= acc_nxt;
        out_valid <= 1'b1;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end else if (state_q == S_DONE && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_neuron_seq_acc.sv
// Directed bench for neuron_seq_acc using three parameterisations.
module tb_neuron_seq_acc;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  // Instance A: 5 pixels, 2 lanes (3 beats, partial last beat)
  logic               a_clear, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic signed [15:0] a_bias, a_out;
  logic [15:0]        a_in_image;
  logic [1:0]         a_in_weight;

  // Instance B: 4 pixels, 4 lanes (single beat)
  logic               b_clear, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic signed [15:0] b_bias, b_out;
  logic [31:0]        b_in_image;
  logic [3:0]         b_in_weight;

  // Instance C: 200 pixels, 8 lanes, 16-bit accumulator (overflow)
  logic               c_clear, c_in_valid, c_in_ready, c_out_valid, c_out_ready;
  logic signed [15:0] c_bias, c_out;
  logic [63:0]        c_in_image;
  logic [7:0]         c_in_weight;

  neuron_seq_acc #(.SIZE_WORD(8), .NUMBER_IMAGE(5), .LANES(2), .ACC_W(16)) u_a (
    .clk(clk), .rst_n(rst_n), .clear(a_clear), .bias(a_bias),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_image(a_in_image),
    .in_weight(a_in_weight), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out(a_out)
  );

  neuron_seq_acc #(.SIZE_WORD(8), .NUMBER_IMAGE(4), .LANES(4), .ACC_W(16)) u_b (
    .clk(clk), .rst_n(rst_n), .clear(b_clear), .bias(b_bias),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_image(b_in_image),
    .in_weight(b_in_weight), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out(b_out)
  );

  neuron_seq_acc #(.SIZE_WORD(8), .NUMBER_IMAGE(200), .LANES(8), .ACC_W(16)) u_c (
    .clk(clk), .rst_n(rst_n), .clear(c_clear), .bias(c_bias),
    .in_valid(c_in_valid), .in_ready(c_in_ready), .in_image(c_in_image),
    .in_weight(c_in_weight), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out(c_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] got,
                     input logic signed [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clk   = 1'b0;
    rst_n = 1'b0;
    a_clear = 0; a_in_valid = 0; a_out_ready = 0; a_bias = 0; a_in_image = '0; a_in_weight = '0;
    b_clear = 0; b_in_valid = 0; b_out_ready = 0; b_bias = 0; b_in_image = '0; b_in_weight = '0;
    c_clear = 0; c_in_valid = 0; c_out_ready = 0; c_bias = 0; c_in_image = '0; c_in_weight = '0;

    // Reset state
    step();
    chk("rst_out", a_out, 0);
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_in_ready", a_in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Partial final beat: 10 -20 +30 +40 -50 = 10, garbage in unused lane
    a_in_valid = 1; a_bias = 0;
    a_in_image = {8'd20, 8'd10}; a_in_weight = 2'b10;
    step();
    a_in_image = {8'd40, 8'd30}; a_in_weight = 2'b11;
    step();
    chk("t1_no_early_valid", a_out_valid, 0);
    a_in_image = {8'hFF, 8'd50}; a_in_weight = 2'b01;
    step();
    chk("t1_out", a_out, 10);
    chk("t1_out_valid", a_out_valid, 1);
    chk("t1_in_ready", a_in_ready, 0);

    // Backpressure: first beat of next image offered but must not be taken
    a_in_image = {8'd5, 8'd7}; a_in_weight = 2'b11; a_bias = 1000;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_out", a_out, 10);
      chk("bp_out_valid", a_out_valid, 1);
      chk("bp_in_ready", a_in_ready, 0);
    end
    a_out_ready = 1;
    step();
    chk("hs_out_valid", a_out_valid, 0);
    chk("hs_in_ready", a_in_ready, 1);
    a_out_ready = 0;
    step();
    // Bias changes after the first beat; it must already be sampled
    a_bias = -5;
    a_in_image = {8'd1, 8'd100}; a_in_weight = 2'b01;
    step();
    a_in_image = {8'd200, 8'd3}; a_in_weight = 2'b10;
    step();
    chk("eval2_out", a_out, 916);
    chk("eval2_out_valid", a_out_valid, 1);
    a_in_valid = 0;

    // Drain, then clear together with beat 2 of 3
    a_out_ready = 1;
    step();
    chk("drain_out_valid", a_out_valid, 0);
    a_out_ready = 0; a_bias = 0; a_in_valid = 1;
    a_in_image = {8'd2, 8'd1}; a_in_weight = 2'b11;
    step();
    a_in_image = {8'd50, 8'd50}; a_in_weight = 2'b11; a_clear = 1;
    step();
    a_clear = 0;
    chk("clr_out_valid", a_out_valid, 0);
    chk("clr_in_ready", a_in_ready, 1);
    chk("clr_out_hold", a_out, 916);
    // Fresh image: +4 -6 +8 +1 -20 = -13
    a_in_image = {8'd6, 8'd4}; a_in_weight = 2'b10;
    step();
    a_in_image = {8'd1, 8'd8}; a_in_weight = 2'b11;
    step();
    chk("clr_no_early_valid", a_out_valid, 0);
    a_in_image = {8'hAA, 8'd20}; a_in_weight = 2'b01;
    step();
    a_in_valid = 0;
    chk("clr_fresh_out", a_out, -13);
    chk("clr_fresh_valid", a_out_valid, 1);

    // Asynchronous reset mid-period while holding a result
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", a_out_valid, 0);
    chk("arst_out", a_out, 0);
    chk("arst_in_ready", a_in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Single beat, bias 100, all subtract: 100 - 10 = 90
    b_bias = 100; b_in_valid = 1;
    b_in_image = {8'd4, 8'd3, 8'd2, 8'd1}; b_in_weight = 4'b0000;
    step();
    b_in_valid = 0;
    chk("single_out", b_out, 90);
    chk("single_out_valid", b_out_valid, 1);
    chk("single_in_ready", b_in_ready, 0);

    // Overflow: 200 * 255 = 51000 into a 16-bit accumulator
    c_bias = 0; c_in_valid = 1; c_in_image = '1; c_in_weight = '1;
    for (int i = 0; i < 24; i++) step();
    chk("ovf_no_early_valid", c_out_valid, 0);
    step();
    c_in_valid = 0;
    chk("ovf_out_valid", c_out_valid, 1);
`ifdef NEURON_SAT_EN
    chk("ovf_out", c_out, 32767);
`else
    chk("ovf_out", c_out, -14536);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
